// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// The functions work at a fixed maximum width and callers size-cast to their own WIDTH.
package arb_pkg;

   localparam int MAX_W     = 64;
   localparam int MAX_IDX_W = 6;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // One-hot to binary; an all-zero input yields index 0.
   function automatic logic [MAX_IDX_W-1:0] onehot_to_index(input logic [MAX_W-1:0] oht);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (oht[i]) idx = idx | MAX_IDX_W'(i);
      end
      return idx;
   endfunction

   // Thermometer mask with every bit strictly above idx set.
   function automatic logic [MAX_W-1:0] thermo_above(input logic [MAX_IDX_W-1:0] idx);
      logic [MAX_W-1:0] t;
      for (int i = 0; i < MAX_W; i++) begin
         t[i] = (i > int'(idx));
      end
      return t;
   endfunction

endpackage

// File: rtl/priority_to_onehot_tree.sv
// Lowest-set-bit priority selector returning a one-hot vector and an any-set flag.
// IMPLEMENTATION 0 searches SPLIT-wide groups first; any other value uses the x & -x form.
module priority_to_onehot_tree #(
   parameter int WIDTH          = 16,
   parameter int SPLIT          = 4,
   parameter int IMPLEMENTATION = 0
) (
   input  logic [WIDTH-1:0] i_req,
   output logic [WIDTH-1:0] o_oht,
   output logic             o_enc_vld
);

   localparam int N_GRP = (WIDTH + SPLIT - 1) / SPLIT;

   assign o_enc_vld = |i_req;

   generate
      if (IMPLEMENTATION == 0) begin : g_tree
         always_comb begin
            logic found_grp;
            logic found_bit;
            logic grp_any;
            // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
            found_grp = 1'b0;
            found_bit = 1'b0;
            grp_any   = 1'b0;
            o_oht     = '0;
            for (int g = 0; g < N_GRP; g++) begin
               grp_any = 1'b0;
               for (int i = g * SPLIT; i < (g + 1) * SPLIT && i < WIDTH; i++) begin
                  grp_any = grp_any | i_req[i];
               end
               if (grp_any && !found_grp) begin
                  found_grp = 1'b1;
                  for (int i = g * SPLIT; i < (g + 1) * SPLIT && i < WIDTH; i++) begin
                     if (i_req[i] && !found_bit) begin
                        o_oht[i]  = 1'b1;
                        found_bit = 1'b1;
                     end
                  end
               end
            end
         end
      end else begin : g_arith
         assign o_oht = i_req & (~i_req + WIDTH'(1));
      end
   endgenerate

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter: grants one requester and holds the grant until its
// last beat transfers, then re-arbitrates in the same cycle with the finisher at lowest priority.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int WIDTH          = 16,
   parameter int SPLIT          = 4,
   parameter int IMPLEMENTATION = 0,
   localparam int IDX_W         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] req_vld,
   input  logic [WIDTH-1:0] req_lst,
   output logic [WIDTH-1:0] req_rdy,
   output logic             gnt_vld,
   output logic             gnt_lst,
   input  logic             gnt_rdy,
   output logic [WIDTH-1:0] gnt_oht,
   output logic [IDX_W-1:0] gnt_idx
);

   arb_state_t       r_state;
   logic [WIDTH-1:0] r_gnt_oht;
   logic [WIDTH-1:0] r_mask;
   logic [IDX_W-1:0] r_gnt_idx;

   logic             w_xfer;
   logic             w_end;
   logic             w_any_m;
   logic             w_any_u;
   logic [WIDTH-1:0] w_mask_nxt;
   logic [WIDTH-1:0] w_mask_eff;
   logic [WIDTH-1:0] w_masked;
   logic [WIDTH-1:0] w_oht_m;
   logic [WIDTH-1:0] w_oht_u;
   logic [WIDTH-1:0] w_win;
   logic [IDX_W-1:0] w_win_idx;

   assign gnt_oht = r_gnt_oht;
   assign gnt_idx = r_gnt_idx;
   assign gnt_vld = |(req_vld & r_gnt_oht);
   assign gnt_lst = |(req_lst & r_gnt_oht);
   assign req_rdy = r_gnt_oht & {WIDTH{gnt_rdy}};

   assign w_xfer = gnt_vld & gnt_rdy;
   assign w_end  = w_xfer & gnt_lst;

   // On a packet end the back-to-back winner must already see the finisher demoted.
   assign w_mask_nxt = WIDTH'(thermo_above(MAX_IDX_W'(r_gnt_idx)));
   assign w_mask_eff = w_end ? w_mask_nxt : r_mask;
   assign w_masked   = req_vld & w_mask_eff;

   priority_to_onehot_tree #(
      .WIDTH          (WIDTH),
      .SPLIT          (SPLIT),
      .IMPLEMENTATION (IMPLEMENTATION)
   ) u_pick_masked (
      .i_req     (w_masked),
      .o_oht     (w_oht_m),
      .o_enc_vld (w_any_m)
   );

   priority_to_onehot_tree #(
      .WIDTH          (WIDTH),
      .SPLIT          (SPLIT),
      .IMPLEMENTATION (IMPLEMENTATION)
   ) u_pick_all (
      .i_req     (req_vld),
      .o_oht     (w_oht_u),
      .o_enc_vld (w_any_u)
   );

   assign w_win     = w_any_m ? w_oht_m : w_oht_u;
   assign w_win_idx = IDX_W'(onehot_to_index(MAX_W'(w_win)));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_gnt_oht <= '0;
         r_gnt_idx <= '0;
         r_mask    <= '1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_u) begin
                  r_state   <= BUSY;
                  r_gnt_oht <= w_win;
                  r_gnt_idx <= w_win_idx;
               end
            end
            BUSY: begin
               if (w_end) begin
                  r_mask <= w_mask_nxt;
                  if (w_any_u) begin
                     r_gnt_oht <= w_win;
                     r_gnt_idx <= w_win_idx;
                  end else begin
                     r_state   <= IDLE;
                     r_gnt_oht <= '0;
                     r_gnt_idx <= '0;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter at WIDTH=4: directed scenarios plus a randomized run against
// a cyclic-scan round-robin reference model.
module tb_rr_arbiter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] req_vld;
   logic [W-1:0] req_lst;
   logic [W-1:0] req_rdy;
   logic         gnt_vld;
   logic         gnt_lst;
   logic         gnt_rdy;
   logic [W-1:0] gnt_oht;
   logic [1:0]   gnt_idx;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rr_arbiter #(
      .WIDTH          (W),
      .SPLIT          (2),
      .IMPLEMENTATION (0)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_vld (req_vld),
      .req_lst (req_lst),
      .req_rdy (req_rdy),
      .gnt_vld (gnt_vld),
      .gnt_lst (gnt_lst),
      .gnt_rdy (gnt_rdy),
      .gnt_oht (gnt_oht),
      .gnt_idx (gnt_idx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n   = 1'b0;
      req_vld = '0;
      req_lst = '0;
      gnt_rdy = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Reference: scan cyclically starting just after the last finisher.
   function automatic int pick(input logic [W-1:0] v, input int last);
      for (int k = 1; k <= W; k++) begin
         if (v[(last + k) % W]) return (last + k) % W;
      end
      return -1;
   endfunction

   initial begin
      logic [W-1:0] seq_oht [4];
      int           seq_idx [5];
      logic [3:0]   rdy_seq;
      logic [W-1:0] nv;
      logic [W-1:0] exp_oht;
      int           g;
      int           last;
      int           wait_cnt [W];

      // Idle after reset
      apply_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("idle_oht", gnt_oht, 0);
         check("idle_rdy", req_rdy, 0);
         check("idle_vld", gnt_vld, 0);
         tick();
      end

      // Two requesters alternate with no bubble
      apply_reset();
      req_vld = 4'b1010;
      req_lst = 4'b1111;
      gnt_rdy = 1'b1;
      tick();
      seq_oht = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
      seq_idx = '{1, 3, 1, 3, 0};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("alt_oht", gnt_oht, seq_oht[k]);
         check("alt_idx", gnt_idx, seq_idx[k]);
         check("alt_vld", gnt_vld, 1);
         tick();
      end

      // All four request: full rotation with wrap
      apply_reset();
      req_vld = 4'b1111;
      req_lst = 4'b1111;
      gnt_rdy = 1'b1;
      tick();
      seq_idx = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("rot_idx", gnt_idx, seq_idx[k]);
         check("rot_onehot", $onehot(gnt_oht), 1);
         tick();
      end

      // Multi-beat packet from requester 2 locks out requester 0
      apply_reset();
      req_vld = 4'b0100;
      tick();
      req_vld = 4'b0101;
      rdy_seq = 4'b1101;
      for (int k = 0; k < 4; k++) begin
         gnt_rdy = rdy_seq[k];
         req_lst = (k == 3) ? 4'b0100 : 4'b0000;
         @(negedge clk);
         check("pkt_oht", gnt_oht, 4'b0100);
         check("pkt_rdy", req_rdy, gnt_rdy ? 4'b0100 : 4'b0000);
         check("pkt_lst", gnt_lst, (k == 3) ? 1 : 0);
         tick();
      end
      @(negedge clk);
      check("pkt_next_oht", gnt_oht, 4'b0001);
      check("pkt_next_idx", gnt_idx, 0);

      // Asynchronous reset while busy
      gnt_rdy = 1'b1;
      req_lst = '0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_oht", gnt_oht, 0);
      check("arst_rdy", req_rdy, 0);
      check("arst_vld", gnt_vld, 0);
      req_vld = 4'b1000;
      tick();
      rst_n = 1'b1;
      #1;
      check("arst_hold", gnt_oht, 0);
      tick();
      @(negedge clk);
      check("arst_regrant_oht", gnt_oht, 4'b1000);
      check("arst_regrant_idx", gnt_idx, 3);

      // Randomized run against the reference model
      apply_reset();
      g    = -1;
      last = W - 1;
      for (int i = 0; i < W; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < W; i++) begin
            if (g == i)          nv[i] = 1'b1;
            else if (req_vld[i]) nv[i] = ($urandom_range(0, 7) != 0);
            else                 nv[i] = ($urandom_range(0, 1) != 0);
         end
         req_vld = nv;
         req_lst = W'($urandom);
         gnt_rdy = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         exp_oht = '0;
         if (g >= 0) exp_oht[g] = 1'b1;
         check("rnd_oht", gnt_oht, exp_oht);
         check("rnd_onehot0", $onehot0(gnt_oht), 1);
         check("rnd_vld", gnt_vld, (g >= 0) ? req_vld[g] : 1'b0);
         check("rnd_lst", gnt_lst, (g >= 0) ? req_lst[g] : 1'b0);
         check("rnd_rdy", req_rdy, gnt_rdy ? exp_oht : '0);
         if (g >= 0) check("rnd_idx", gnt_idx, g);
         check("rnd_hold", (gnt_oht == '0) || ((req_vld & gnt_oht) != '0), 1);
         // Fairness from observed grants: packet ends seen while a requester waits.
         for (int i = 0; i < W; i++) begin
            if (!req_vld[i] || gnt_oht[i]) begin
               wait_cnt[i] = 0;
            end else if (gnt_vld && gnt_rdy && gnt_lst) begin
               wait_cnt[i]++;
               check("rnd_fair", wait_cnt[i] <= W - 1, 1);
            end
         end
         if (g < 0) begin
            g = pick(req_vld, last);
         end else if (req_vld[g] && gnt_rdy && req_lst[g]) begin
            last = g;
            g    = pick(req_vld, last);
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
